// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and parameter bounds for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {HOLD, STABLE, RELEASE, RUN} state_t;
  localparam int MAX_STAGES = 8;
endpackage

// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-qualified, staged release of per-subsystem resets with lock-loss counting
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE = 1024,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 16,
  parameter int REQ_HOLD    = 16,
  parameter int CNT_W       = 8
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              clk_locked,
  input  logic              sw_rst_req,
  output logic [STAGES-1:0] stage_rst,
  output logic              sys_ready,
  output logic [CNT_W-1:0]  lock_loss_cnt
);
  localparam int HC_W = $clog2(REQ_HOLD + 1);
  localparam int SC_W = $clog2(LOCK_STABLE + 1);
  localparam int GC_W = $clog2(STAGE_GAP + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(REQ_HOLD);
  localparam logic [SC_W-1:0] STABLE_MAX = SC_W'(LOCK_STABLE);
  localparam logic [GC_W-1:0] GAP_MAX = GC_W'(STAGE_GAP);
  if (LOCK_STABLE < 1 || STAGES < 1 || STAGES > MAX_STAGES || STAGE_GAP < 1 || REQ_HOLD < 1 || CNT_W < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end
  state_t r_state;
  logic [HC_W-1:0] r_hold_cnt;
  logic [SC_W-1:0] r_stable_cnt;
  logic [GC_W-1:0] r_gap_cnt;
  logic [SC_W-1:0] w_stable_inc;
  logic [GC_W-1:0] w_gap_inc;
  logic [STAGES-1:0] w_shift;
  logic w_abort;
  // stage_rst is a thermometer: shifting left releases the next stage in order
  always_comb begin
    w_stable_inc = r_stable_cnt + SC_W'(1);
    w_gap_inc = r_gap_cnt + GC_W'(1);
    w_shift = stage_rst << 1;
    w_abort = !clk_locked || sw_rst_req;
  end
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_state <= HOLD;
      r_hold_cnt <= '0;
      r_stable_cnt <= '0;
      r_gap_cnt <= '0;
      stage_rst <= '1;
      sys_ready <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          stage_rst <= '1;
          sys_ready <= 1'b0;
          if (sw_rst_req) r_hold_cnt <= '0;
          else if (r_hold_cnt == HOLD_MAX && clk_locked) begin
            r_state <= STABLE;
            r_stable_cnt <= '0;
          end else if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + HC_W'(1);
        end
        STABLE: begin
          if (w_abort) begin
            r_state <= HOLD;
            r_hold_cnt <= '0;
          end else if (w_stable_inc == STABLE_MAX) begin
            r_state <= (w_shift == '0) ? RUN : RELEASE;
            stage_rst <= w_shift;
            r_gap_cnt <= '0;
          end else r_stable_cnt <= w_stable_inc;
        end
        default: begin
          if (w_abort) begin
            r_state <= HOLD;
            r_hold_cnt <= '0;
            stage_rst <= '1;
            sys_ready <= 1'b0;
            if (!clk_locked && lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
          end else if (r_state == RUN) sys_ready <= 1'b1;
          else if (w_gap_inc == GAP_MAX) begin
            r_state <= (w_shift == '0) ? RUN : RELEASE;
            stage_rst <= w_shift;
            r_gap_cnt <= '0;
          end else r_gap_cnt <= w_gap_inc;
        end
      endcase
    end
  end
endmodule
